// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the data-cache port between loads and stores, one transaction at a time.
// Optional DCACHE_ARB_RR_EN: round-robin on ties instead of fixed store priority.
module dcache_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W = 13,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [TAG_W-1:0]  ld_tag,
  input  logic              ld_kill,
  output logic              ld_accept,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [TAG_W-1:0]  st_tag,
  output logic              st_accept,
  output logic              st_done,
  output logic              reqcyc,
  output logic [ADDR_W-1:0] req,
  output logic [DATA_W-1:0] reqdata,
  output logic [TAG_W-1:0]  reqtag,
  input  logic              reqack,
  input  logic              respcyc,
  input  logic [DATA_W-1:0] resp,
  output logic              respack,
  input  logic              writeack,
  output logic              busy,
  output logic              err_timeout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_disc;
  logic w_st_win, w_ld_win, w_wait, w_rd_done, w_wr_done, w_tmo, w_rd_busy;
`ifdef DCACHE_ARB_RR_EN
  logic r_last_ld;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_last_ld <= 1'b0;
    else if (w_st_win || w_ld_win) r_last_ld <= w_ld_win;
  assign w_st_win = (r_state == IDLE) && st_valid && (!ld_valid || r_last_ld);
`else
  assign w_st_win = (r_state == IDLE) && st_valid;
`endif
  assign w_ld_win  = (r_state == IDLE) && ld_valid && !w_st_win;
  assign w_wait    = (r_state == RD_WAIT) || (r_state == WR_WAIT);
  assign w_rd_busy = (r_state == RD_REQ) || (r_state == RD_WAIT);
  assign w_rd_done = (r_state == RD_WAIT) && respcyc;
  assign w_wr_done = ((r_state == WR_WAIT) || (r_state == WR_REQ && reqack)) && writeack;
  // a completing response in the final wait cycle takes precedence over the timeout
  assign w_tmo = w_wait && !w_rd_done && !w_wr_done && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_st_win ? WR_REQ : (w_ld_win ? RD_REQ : IDLE);
      RD_REQ:  w_next = reqack ? RD_WAIT : RD_REQ;
      RD_WAIT: w_next = (w_rd_done || w_tmo) ? IDLE : RD_WAIT;
      WR_REQ:  w_next = reqack ? (writeack ? IDLE : WR_WAIT) : WR_REQ;
      WR_WAIT: w_next = (w_wr_done || w_tmo) ? IDLE : WR_WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt       <= '0;
      r_disc      <= 1'b0;
      reqcyc      <= 1'b0;
      req         <= '0;
      reqdata     <= '0;
      reqtag      <= '0;
      ld_accept   <= 1'b0;
      st_accept   <= 1'b0;
      ld_rvalid   <= 1'b0;
      ld_rdata    <= '0;
      st_done     <= 1'b0;
      respack     <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      r_cnt       <= w_wait ? r_cnt + CNT_W'(1) : '0;
      r_disc      <= (w_next == IDLE) ? 1'b0 : (r_disc || (ld_kill && w_rd_busy));
      reqcyc      <= (w_next == RD_REQ) || (w_next == WR_REQ);
      ld_accept   <= w_ld_win;
      st_accept   <= w_st_win;
      ld_rvalid   <= w_rd_done && !(r_disc || ld_kill);
      st_done     <= w_wr_done;
      respack     <= w_rd_done;
      busy        <= w_next != IDLE;
      err_timeout <= err_timeout || w_tmo;
      if (w_rd_done) ld_rdata <= resp;
      if (w_st_win || w_ld_win) begin
        req     <= w_st_win ? st_addr : ld_addr;
        reqdata <= w_st_win ? st_data : '0;
        reqtag  <= w_st_win ? st_tag : ld_tag;
      end
    end
endmodule
